piece_mover_param: RTL and testbench
====================================

Name: piece_mover_param

Overview:
- Parametrised successor of the single-step piece mover for the Tetris chip.
- Owns the locked-cell board and one active piece.
- Per requested step: applies one user move (left/right/rotate) if legal, then drops the piece one row. If the drop is blocked, the piece is merged into the board.
- Sits between the input debouncer/game controller (step and spawn requests) and the display driver (board_state).

Parameters:
- COLS, 4: board width in cells (>=2).
- ROWS, 8: board height in cells (>=2).
- SPAWN_COL, 1: anchor column for new pieces (0..COLS-2).

Ports:
- clka  in  1  single system clock; all logic on rising edge.
- restart_n  in  1  reset, synchronous, active-low.
- spawn_req  in  1  load new piece (honoured only in IDLE with no active piece).
- spawn_type  in  2  piece type for spawn.
- step_req  in  1  start one move+fall step (honoured only in IDLE with active piece).
- left, right, rotate  in  1 each  user input, sampled with step_req.
- piece_active  out  1  active piece present.
- piece_row  out  $clog2(ROWS)  anchor row (row 0 = top).
- piece_col  out  $clog2(COLS)  anchor column.
- piece_rot  out  2  rotation.
- board_state  out  COLS*ROWS  locked cells OR active piece overlay; bit = row*COLS+col.
- step_done  out  1  one-cycle pulse at step completion.
- touched  out  1  one-cycle pulse, coincident with step_done, when the step locked the piece.
- game_over  out  1  sticky; set on spawn collision.
- lines_cleared  out  8  running count of cleared rows (saturates at 255).

Behaviour:
- Piece geometry:
  - Anchor = bottom-left cell of a 2x2 box.
  - Mask bits: b0=(r,c), b1=(r,c+1), b2=(r-1,c), b3=(r-1,c+1).
  - Type0: 0001 for all rotations.
  - Type1: rot0/2 = 0101, rot1/3 = 0011.
  - Type2: 1111.
  - Type3: rot0 = 0111, rot1 = 1101, rot2 = 1110, rot3 = 1011.
- Legality: every set-mask cell has column <COLS, row <ROWS, and is not locked.
  - Cells at row -1 (above the top) count as empty and legal.
  - Rotation is (rot+1) mod 4, with no wall kick.
- Input priority: left > right > rotate. An illegal move leaves position and rotation unchanged.
- FSM states: IDLE, MOVE, FALL, LOCK, CLEAR, DONE. All transitions are registered.
  - IDLE + spawn_req with !piece_active: load row 0, SPAWN_COL, rot 0, spawn_type.
    - Legal: piece_active=1, game_over unchanged.
    - Illegal: piece_active stays 0, game_over=1.
    - Stays in IDLE.
  - IDLE + step_req with piece_active and !game_over: latch left/right/rotate, go to MOVE.
  - MOVE: apply the latched move if legal, go to FALL.
  - FALL:
    - row+1 legal: row++ and go to DONE.
    - Otherwise go to LOCK.
  - LOCK: OR piece cells into the locked board (cells at row -1 are discarded), piece_active=0, go to CLEAR.
  - CLEAR: goes directly to DONE unless LINE_CLEAR_EN is defined.
  - DONE: step_done=1 (touched=1 if LOCK was visited), go to IDLE.
- Latency (req seen in cycle N):
  - Non-locking step: step_done in cycle N+3.
  - Locking step, no clear: step_done in cycle N+4.
- Requests outside IDLE are ignored; no queuing. The requester holds step_req until it sees step_done.
- board_state is registered and updated the cycle after any piece or board change.
- Reset (restart_n=0 at an edge), including mid-step:
  - State returns to IDLE.
  - board_state, piece_active, piece_row/col/rot, step_done, touched, game_over and lines_cleared are all 0.
  - Any in-progress step is aborted with no step_done.

Optional Feature:
- Macro LINE_CLEAR_EN.
- Defined: CLEAR scans rows from bottom (ROWS-1) to top, one row per cycle.
  - A full row is removed; all rows above shift down one, and row 0 fills with 0.
  - The same row index is rescanned after a shift.
  - lines_cleared increments per removed row.
  - DONE follows the row-0 check.
- Undefined: CLEAR lasts zero cycles and lines_cleared is tied to 0.

Test Plan:
- Reset, spawn type0 -> piece_active=1, row=0, col=1, board_state=32'h0000_0002; step with no input -> step_done 3 cycles after req, row=1, board_state bit5 set.
- Type1 rot0 at col 0, step with left=1 -> col stays 0, row+1. Same piece at col 3, rotate -> rot stays 0 (horizontal illegal), row+1.
- Spawn type2 at col 1, issue 8 steps -> 7th step leaves row=7; 8th step touched=1, piece_active=0, locked bits 25,26,29,30.
- Column 1 filled to row 0 with type2 pieces, then spawn_req -> game_over=1, piece_active=0; subsequent step_req ignored.
- LINE_CLEAR_EN: pre-fill bits 28,29,30 and bit 24, drop type0 into col 3 -> row 7 cleared, lines_cleared=1, bit 24 moves to bit 28.
- Assert restart_n=0 while in FALL -> next cycle all outputs 0, no step_done pulse.

Source files
------------

// File: rtl/piece_mover_param.sv
// Parametrised single-step piece mover: locked board, one active piece, move+fall per step.
// Optional row clearing is compiled in with `define LINE_CLEAR_EN.
module piece_mover_param #(
    parameter int unsigned COLS      = 4,
    parameter int unsigned ROWS      = 8,
    parameter int unsigned SPAWN_COL = 1
) (
    input  logic                    clka,
    input  logic                    restart_n,
    input  logic                    spawn_req,
    input  logic [1:0]              spawn_type,
    input  logic                    step_req,
    input  logic                    left,
    input  logic                    right,
    input  logic                    rotate,
    output logic                    piece_active,
    output logic [$clog2(ROWS)-1:0] piece_row,
    output logic [$clog2(COLS)-1:0] piece_col,
    output logic [1:0]              piece_rot,
    output logic [COLS*ROWS-1:0]    board_state,
    output logic                    step_done,
    output logic                    touched,
    output logic                    game_over,
    output logic [7:0]              lines_cleared
);

    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned NC    = COLS * ROWS;
    localparam int          NCOLS = int'(COLS);
    localparam int          NROWS = int'(ROWS);

    typedef enum logic [2:0] {
        StIdle,
        StMove,
        StFall,
        StLock,
        StClear,
        StDone
    } state_e;

    // Mask bits: b0=(r,c) b1=(r,c+1) b2=(r-1,c) b3=(r-1,c+1).
    function automatic logic [3:0] piece_mask(input logic [1:0] typ, input logic [1:0] rot);
        logic [3:0] m;
        unique case (typ)
            2'd0: m = 4'b0001;
            2'd1: m = rot[0] ? 4'b0011 : 4'b0101;
            2'd2: m = 4'b1111;
            2'd3: begin
                unique case (rot)
                    2'd0: m = 4'b0111;
                    2'd1: m = 4'b1101;
                    2'd2: m = 4'b1110;
                    2'd3: m = 4'b1011;
                endcase
            end
        endcase
        return m;
    endfunction

    // True when any set cell falls outside the board; row -1 is allowed.
    function automatic logic piece_oob(input logic [1:0] typ, input logic [1:0] rot,
                                       input int row, input int col);
        logic [3:0] m;
        logic       o;
        int         cr;
        int         cc;
        m = piece_mask(typ, rot);
        o = 1'b0;
        for (int b = 0; b < 4; b++) begin
            cr = row - b / 2;
            cc = col + b % 2;
            if (m[b] && (cc < 0 || cc >= NCOLS || cr >= NROWS)) o = 1'b1;
        end
        return o;
    endfunction

    // On-board cells of a piece; cells above the top row are dropped.
    function automatic logic [NC-1:0] piece_cells(input logic [1:0] typ, input logic [1:0] rot,
                                                  input int row, input int col);
        logic [3:0]    m;
        logic [NC-1:0] cells;
        m     = piece_mask(typ, rot);
        cells = '0;
        for (int i = 0; i < int'(NC); i++) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b] && (i / NCOLS == row - b / 2) && (i % NCOLS == col + b % 2)) begin
                    cells[i] = 1'b1;
                end
            end
        end
        return cells;
    endfunction

    function automatic logic fits(input logic [1:0] typ, input logic [1:0] rot,
                                  input int row, input int col, input logic [NC-1:0] brd);
        return !piece_oob(typ, rot, row, col) && ((piece_cells(typ, rot, row, col) & brd) == '0);
    endfunction

`ifdef LINE_CLEAR_EN
    function automatic logic row_is_full(input logic [NC-1:0] brd, input int k);
        logic f;
        f = 1'b1;
        for (int i = 0; i < int'(NC); i++) begin
            if ((i / NCOLS == k) && !brd[i]) f = 1'b0;
        end
        return f;
    endfunction

    // Remove row k: rows above it move down one, row 0 becomes empty.
    function automatic logic [NC-1:0] drop_row(input logic [NC-1:0] brd, input int k);
        logic [NC-1:0] shifted;
        logic [NC-1:0] res;
        shifted = brd << COLS;
        for (int i = 0; i < int'(NC); i++) begin
            res[i] = (i / NCOLS > k) ? brd[i] : shifted[i];
        end
        return res;
    endfunction
`endif

    state_e        state_q, state_d;
    logic [NC-1:0] board_q, board_d;
    logic [NC-1:0] board_state_q, board_state_d;
    logic          active_q, active_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    rot_q, rot_d;
    logic [1:0]    type_q, type_d;
    logic          mv_left_q, mv_left_d;
    logic          mv_right_q, mv_right_d;
    logic          mv_rot_q, mv_rot_d;
    logic          lock_q, lock_d;
    logic          game_over_q, game_over_d;
`ifdef LINE_CLEAR_EN
    logic [RW-1:0] clr_row_q, clr_row_d;
    logic [7:0]    lines_q, lines_d;
    logic          row_full;
`endif

    logic [NC-1:0] cur_cells;
    logic          spawn_ok, left_ok, right_ok, rot_ok, fall_ok;

    assign cur_cells = piece_cells(type_q, rot_q, int'(row_q), int'(col_q));
    assign spawn_ok  = fits(spawn_type, 2'd0, 0, int'(SPAWN_COL), board_q);
    assign left_ok   = fits(type_q, rot_q, int'(row_q), int'(col_q) - 1, board_q);
    assign right_ok  = fits(type_q, rot_q, int'(row_q), int'(col_q) + 1, board_q);
    assign rot_ok    = fits(type_q, rot_q + 2'd1, int'(row_q), int'(col_q), board_q);
    assign fall_ok   = fits(type_q, rot_q, int'(row_q) + 1, int'(col_q), board_q);
`ifdef LINE_CLEAR_EN
    assign row_full  = row_is_full(board_q, int'(clr_row_q));
`endif

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        active_d    = active_q;
        row_d       = row_q;
        col_d       = col_q;
        rot_d       = rot_q;
        type_d      = type_q;
        mv_left_d   = mv_left_q;
        mv_right_d  = mv_right_q;
        mv_rot_d    = mv_rot_q;
        lock_d      = lock_q;
        game_over_d = game_over_q;
`ifdef LINE_CLEAR_EN
        clr_row_d   = clr_row_q;
        lines_d     = lines_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (spawn_req && !active_q) begin
                    row_d  = '0;
                    col_d  = CW'(SPAWN_COL);
                    rot_d  = 2'd0;
                    type_d = spawn_type;
                    if (spawn_ok) active_d = 1'b1;
                    else          game_over_d = 1'b1;
                end else if (step_req && active_q && !game_over_q) begin
                    mv_left_d  = left;
                    mv_right_d = right;
                    mv_rot_d   = rotate;
                    lock_d     = 1'b0;
                    state_d    = StMove;
                end
            end
            StMove: begin
                // Only the highest-priority request is tried; no fallback to the next one.
                if (mv_left_q) begin
                    if (left_ok) col_d = col_q - 1'b1;
                end else if (mv_right_q) begin
                    if (right_ok) col_d = col_q + 1'b1;
                end else if (mv_rot_q) begin
                    if (rot_ok) rot_d = rot_q + 2'd1;
                end
                state_d = StFall;
            end
            StFall: begin
                if (fall_ok) begin
                    row_d   = row_q + 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StLock;
                end
            end
            StLock: begin
                board_d  = board_q | cur_cells;
                active_d = 1'b0;
                lock_d   = 1'b1;
`ifdef LINE_CLEAR_EN
                clr_row_d = RW'(ROWS - 1);
                state_d   = StClear;
`else
                state_d   = StDone;
`endif
            end
            StClear: begin
`ifdef LINE_CLEAR_EN
                // After a removal the same row index is rescanned.
                if (row_full) begin
                    board_d = drop_row(board_q, int'(clr_row_q));
                    if (lines_q != 8'hFF) lines_d = lines_q + 8'd1;
                end else if (clr_row_q == '0) begin
                    state_d = StDone;
                end else begin
                    clr_row_d = clr_row_q - 1'b1;
                end
`else
                state_d = StDone;
`endif
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign board_state_d = board_q | (active_q ? cur_cells : '0);

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            state_q       <= StIdle;
            board_q       <= '0;
            board_state_q <= '0;
            active_q      <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            rot_q         <= 2'd0;
            type_q        <= 2'd0;
            mv_left_q     <= 1'b0;
            mv_right_q    <= 1'b0;
            mv_rot_q      <= 1'b0;
            lock_q        <= 1'b0;
            game_over_q   <= 1'b0;
`ifdef LINE_CLEAR_EN
            clr_row_q     <= '0;
            lines_q       <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            board_state_q <= board_state_d;
            active_q      <= active_d;
            row_q         <= row_d;
            col_q         <= col_d;
            rot_q         <= rot_d;
            type_q        <= type_d;
            mv_left_q     <= mv_left_d;
            mv_right_q    <= mv_right_d;
            mv_rot_q      <= mv_rot_d;
            lock_q        <= lock_d;
            game_over_q   <= game_over_d;
`ifdef LINE_CLEAR_EN
            clr_row_q     <= clr_row_d;
            lines_q       <= lines_d;
`endif
        end
    end

    assign piece_active = active_q;
    assign piece_row    = row_q;
    assign piece_col    = col_q;
    assign piece_rot    = rot_q;
    assign board_state  = board_state_q;
    assign step_done    = (state_q == StDone);
    assign touched      = (state_q == StDone) && lock_q;
    assign game_over    = game_over_q;
`ifdef LINE_CLEAR_EN
    assign lines_cleared = lines_q;
`else
    assign lines_cleared = 8'd0;
`endif

endmodule

// File: tb/tb_piece_mover_param.sv
// Scoreboard bench for piece_mover_param: a behavioural board model predicts each step's result.
module tb_piece_mover_param;

    localparam int COLS = 4;
    localparam int ROWS = 8;
    localparam int SPAWN_COL = 1;

    logic                    clka = 1'b0;
    logic                    restart_n;
    logic                    spawn_req;
    logic [1:0]              spawn_type;
    logic                    step_req;
    logic                    left;
    logic                    right;
    logic                    rotate;
    logic                    piece_active;
    logic [$clog2(ROWS)-1:0] piece_row;
    logic [$clog2(COLS)-1:0] piece_col;
    logic [1:0]              piece_rot;
    logic [COLS*ROWS-1:0]    board_state;
    logic                    step_done;
    logic                    touched;
    logic                    game_over;
    logic [7:0]              lines_cleared;

    piece_mover_param #(
        .COLS(COLS),
        .ROWS(ROWS),
        .SPAWN_COL(SPAWN_COL)
    ) dut (
        .clka(clka),
        .restart_n(restart_n),
        .spawn_req(spawn_req),
        .spawn_type(spawn_type),
        .step_req(step_req),
        .left(left),
        .right(right),
        .rotate(rotate),
        .piece_active(piece_active),
        .piece_row(piece_row),
        .piece_col(piece_col),
        .piece_rot(piece_rot),
        .board_state(board_state),
        .step_done(step_done),
        .touched(touched),
        .game_over(game_over),
        .lines_cleared(lines_cleared)
    );

    always #5 clka = ~clka;

    typedef struct {
        int          row;
        int          col;
        int          rot;
        bit          active;
        bit          touched;
        int          lat;
        logic [31:0] board;
        int          lines;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state.
    logic [31:0] m_board;
    int m_row, m_col, m_rot, m_type, m_lines;
    bit m_act, m_go;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_mask(input int t, input int rot);
        case (t)
            0: return 4'b0001;
            1: return (rot % 2 == 1) ? 4'b0011 : 4'b0101;
            2: return 4'b1111;
            default: begin
                case (rot)
                    0: return 4'b0111;
                    1: return 4'b1101;
                    2: return 4'b1110;
                    default: return 4'b1011;
                endcase
            end
        endcase
    endfunction

    function automatic bit m_fits(input int t, input int rot, input int row, input int col);
        logic [3:0] m;
        m = m_mask(t, rot);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) begin
                int cr, cc;
                cr = row - b / 2;
                cc = col + b % 2;
                if (cc < 0 || cc >= COLS || cr >= ROWS) return 0;
                if (cr >= 0 && m_board[cr*COLS+cc]) return 0;
            end
        end
        return 1;
    endfunction

    function automatic logic [31:0] m_piece();
        logic [31:0] res;
        logic [3:0]  m;
        res = '0;
        m = m_mask(m_type, m_rot);
        for (int b = 0; b < 4; b++) begin
            if (m[b] && (m_row - b / 2) >= 0) res[(m_row-b/2)*COLS+m_col+b%2] = 1'b1;
        end
        return res;
    endfunction

    function automatic logic [31:0] m_view();
        return m_act ? (m_board | m_piece()) : m_board;
    endfunction

    task automatic m_reset();
        m_board = '0;
        m_row = 0; m_col = 0; m_rot = 0; m_type = 0; m_lines = 0;
        m_act = 0; m_go = 0;
        sb.delete();
    endtask

    task automatic m_step(input bit l, input bit r, input bit ro, output exp_t e);
        if (l) begin
            if (m_fits(m_type, m_rot, m_row, m_col - 1)) m_col--;
        end else if (r) begin
            if (m_fits(m_type, m_rot, m_row, m_col + 1)) m_col++;
        end else if (ro) begin
            if (m_fits(m_type, (m_rot + 1) % 4, m_row, m_col)) m_rot = (m_rot + 1) % 4;
        end
        if (m_fits(m_type, m_rot, m_row + 1, m_col)) begin
            m_row++;
            e.touched = 0;
            e.lat = 3;
        end else begin
            m_board = m_board | m_piece();
            m_act = 0;
            e.touched = 1;
            e.lat = 4;
`ifdef LINE_CLEAR_EN
            begin
                int k, removed;
                bit full;
                k = ROWS - 1;
                removed = 0;
                while (k >= 0) begin
                    full = 1;
                    for (int c = 0; c < COLS; c++) if (!m_board[k*COLS+c]) full = 0;
                    if (full) begin
                        for (int rr = k; rr > 0; rr--)
                            for (int c = 0; c < COLS; c++)
                                m_board[rr*COLS+c] = m_board[(rr-1)*COLS+c];
                        for (int c = 0; c < COLS; c++) m_board[c] = 1'b0;
                        removed++;
                        if (m_lines < 255) m_lines++;
                    end else begin
                        k--;
                    end
                end
                e.lat = 4 + ROWS + removed;
            end
`endif
        end
        e.row = m_row;
        e.col = m_col;
        e.rot = m_rot;
        e.active = m_act;
        e.board = m_view();
        e.lines = m_lines;
    endtask

    task automatic do_reset();
        restart_n = 1'b0;
        spawn_req = 1'b0; spawn_type = 2'd0;
        step_req = 1'b0; left = 1'b0; right = 1'b0; rotate = 1'b0;
        @(negedge clka);
        @(negedge clka);
        check_eq("rst_active", piece_active, 0);
        check_eq("rst_row", piece_row, 0);
        check_eq("rst_col", piece_col, 0);
        check_eq("rst_rot", piece_rot, 0);
        check_eq("rst_board", board_state, 0);
        check_eq("rst_done", step_done, 0);
        check_eq("rst_touched", touched, 0);
        check_eq("rst_game_over", game_over, 0);
        check_eq("rst_lines", lines_cleared, 0);
        restart_n = 1'b1;
        @(negedge clka);
        m_reset();
    endtask

    task automatic do_spawn(input int t);
        m_type = t; m_row = 0; m_col = SPAWN_COL; m_rot = 0;
        if (m_fits(t, 0, 0, SPAWN_COL)) m_act = 1;
        else m_go = 1;
        spawn_req = 1'b1;
        spawn_type = 2'(t);
        @(negedge clka);
        spawn_req = 1'b0;
        @(negedge clka);
        check_eq("spawn_active", piece_active, m_act);
        check_eq("spawn_game_over", game_over, m_go);
        check_eq("spawn_board", board_state, m_view());
        if (m_act) begin
            check_eq("spawn_row", piece_row, 0);
            check_eq("spawn_col", piece_col, SPAWN_COL);
            check_eq("spawn_rot", piece_rot, 0);
        end
    endtask

    task automatic do_step(input bit l, input bit r, input bit ro);
        exp_t e;
        int   cyc;
        bit   seen;
        m_step(l, r, ro, e);
        sb.push_back(e);
        left = l; right = r; rotate = ro;
        step_req = 1'b1;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 64) begin
            @(negedge clka);
            cyc++;
            if (step_done) seen = 1;
        end
        step_req = 1'b0; left = 1'b0; right = 1'b0; rotate = 1'b0;
        check_eq("step_done_seen", seen, 1);
        e = sb.pop_front();
        if (seen) begin
            check_eq("step_latency", cyc, e.lat);
            check_eq("step_row", piece_row, e.row);
            check_eq("step_col", piece_col, e.col);
            check_eq("step_rot", piece_rot, e.rot);
            check_eq("step_active", piece_active, e.active);
            check_eq("step_touched", touched, e.touched);
            check_eq("step_lines", lines_cleared, e.lines);
            @(negedge clka);
            check_eq("step_done_pulse", step_done, 0);
            check_eq("step_board", board_state, e.board);
        end
    endtask

    task automatic drop_rest();
        int g;
        g = 0;
        while (m_act && g < ROWS + 2) begin
            do_step(0, 0, 0);
            g++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clka);
        do_reset();

        // Type0 basic spawn and one plain step.
        do_spawn(0);
        check_eq("t0_spawn_board", board_state, 32'h0000_0002);
        do_step(0, 0, 0);
        check_eq("t0_step_board", board_state, 32'h0000_0020);
        drop_rest();
        check_eq("t0_locked_board", board_state, 32'h2000_0000);

        // Type1: walls block left at col 0 and the horizontal rotation at col 3.
        do_reset();
        do_spawn(1);
        do_step(1, 0, 0);
        do_step(1, 0, 0);
        check_eq("t1_left_wall_col", piece_col, 0);
        do_step(0, 1, 0);
        do_step(0, 1, 0);
        do_step(0, 1, 0);
        check_eq("t1_right_wall_col", piece_col, 3);
        do_step(0, 0, 1);
        check_eq("t1_rot_blocked", piece_rot, 0);
        check_eq("t1_row", piece_row, 6);

        // Type2 falls the full height, then column 1 fills up to game over.
        do_reset();
        do_spawn(2);
        for (int i = 0; i < 7; i++) do_step(0, 0, 0);
        check_eq("t2_row7", piece_row, 7);
        do_step(0, 0, 0);
        check_eq("t2_locked_board", board_state, 32'h6600_0000);
        for (int i = 0; i < 3; i++) begin
            do_spawn(2);
            drop_rest();
        end
        do_spawn(2);
        check_eq("go_set", game_over, 1);
        begin
            int dones;
            dones = 0;
            step_req = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clka);
                if (step_done) dones++;
            end
            step_req = 1'b0;
            check_eq("go_step_ignored", dones, 0);
            check_eq("go_sticky", game_over, 1);
        end

`ifdef LINE_CLEAR_EN
        // Bottom row filled by four singles; the cell above row 7 moves down.
        do_reset();
        do_spawn(0); do_step(1, 0, 0); drop_rest();
        do_spawn(0); do_step(1, 0, 0); drop_rest();
        do_spawn(0); drop_rest();
        do_spawn(0); do_step(0, 1, 0); drop_rest();
        do_spawn(0); do_step(0, 1, 0); do_step(0, 1, 0); drop_rest();
        check_eq("clr_lines", lines_cleared, 1);
        check_eq("clr_board", board_state, 32'h1000_0000);
`endif

        // Random play checked against the model.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int it = 0; it < 60; it++) begin
                if (!m_act) begin
                    if (m_go) break;
                    do_spawn(int'($urandom_range(0, 3)));
                end else begin
                    do_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)));
                end
            end
        end

        // Reset while the step is in FALL aborts it without a step_done.
        do_reset();
        do_spawn(0);
        step_req = 1'b1;
        @(negedge clka);
        @(negedge clka);
        restart_n = 1'b0;
        step_req = 1'b0;
        @(negedge clka);
        check_eq("midrst_active", piece_active, 0);
        check_eq("midrst_row", piece_row, 0);
        check_eq("midrst_col", piece_col, 0);
        check_eq("midrst_board", board_state, 0);
        check_eq("midrst_done", step_done, 0);
        check_eq("midrst_touched", touched, 0);
        restart_n = 1'b1;
        begin
            int dones;
            dones = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clka);
                if (step_done) dones++;
            end
            check_eq("midrst_no_done", dones, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
